// File: rtl/shift_cmd_pkg.sv
// Shared command layout for the shift command FIFO and the 4-bit barrel shifter.
package shift_cmd_pkg;

  localparam int DATA_LSB = 0;
  localparam int DATA_W   = 4;
  localparam int AMT_LSB  = 4;
  localparam int AMT_W    = 2;
  localparam int DIR_BIT  = 6;
  localparam int MODE_BIT = 7;
  localparam int CMD_W    = 8;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } shift_dir_e;

  typedef enum logic {
    MODE_LOGICAL = 1'b0,
    MODE_ROTATE  = 1'b1
  } shift_mode_e;

  // Field order mirrors the bit layout of the 8-bit command word.
  typedef struct packed {
    shift_mode_e             mode;
    shift_dir_e              dir;
    logic [AMT_W-1:0]        amt;
    logic [DATA_W-1:0]       data;
  } shift_cmd_t;

endpackage

// File: rtl/shift_cmd_decode.sv
// Combinational slicer from a raw 8-bit shift command to its fields; no arithmetic.
module shift_cmd_decode
  import shift_cmd_pkg::*;
(
  input  logic [CMD_W-1:0] word_i,
  output shift_cmd_t       cmd_o
);

  assign cmd_o.data = word_i[DATA_LSB +: DATA_W];
  assign cmd_o.amt  = word_i[AMT_LSB +: AMT_W];
  assign cmd_o.dir  = shift_dir_e'(word_i[DIR_BIT]);
  assign cmd_o.mode = shift_mode_e'(word_i[MODE_BIT]);

endmodule

// File: rtl/shift_cmd_fifo.sv
// First-word-fall-through command FIFO feeding the barrel shifter.
// Optional occupancy high-water mark enabled by defining SHIFT_CMD_HWM_EN.
module shift_cmd_fifo
  import shift_cmd_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_cmd,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       cmd_data,
  output logic [1:0]       cmd_amt,
  output logic             cmd_dir,
  output logic             cmd_mode,
  output logic [PTR_W:0]   count,
  output logic [PTR_W:0]   hwm
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  shift_cmd_t       head;

  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);

  // Flush wins over any handshake in the same cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + PTR_ONE;
      if (pop)  rp_d = rp_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      if (push) mem_q[wp_q] <= in_cmd;
    end
  end

  // Head is decoded from registered state only, so cmd_* move on clock edges.
  shift_cmd_decode u_decode (
    .word_i (mem_q[rp_q]),
    .cmd_o  (head)
  );

  assign cmd_data = head.data;
  assign cmd_amt  = head.amt;
  assign cmd_dir  = head.dir;
  assign cmd_mode = head.mode;
  assign count    = count_q;

`ifdef SHIFT_CMD_HWM_EN
  logic [PTR_W:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (count_d > hwm_q) hwm_d = (count_d > CNT_FULL) ? CNT_FULL : count_d;
  end

  // Survives flush on purpose; only rst clears the mark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hwm_q <= '0;
    else     hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

endmodule
